// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline definitions: datapath width, bubble encoding, reset PC and the IF/ID bundle.
package rv32_pipe_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] inst;
        logic            valid;
        logic            fault;
    } ifid_t;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: priority reset > bubble > hold > load.
// A bubble clears inst/valid/fault but keeps the previous PC fields.
module if_id_reg
    import rv32_pipe_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INST = rv32_pipe_pkg::NOP_INST
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_bubble,
    input  logic  i_hold,
    input  ifid_t i_load_dat,
    output ifid_t o_ifid_dat
);

    ifid_t r_ifid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid.pc       <= '0;
            r_ifid.pc_plus4 <= 32'd4;
            r_ifid.inst     <= BUBBLE_INST;
            r_ifid.valid    <= 1'b0;
            r_ifid.fault    <= 1'b0;
        end else if (i_bubble) begin
            r_ifid.inst     <= BUBBLE_INST;
            r_ifid.valid    <= 1'b0;
            r_ifid.fault    <= 1'b0;
        end else if (!i_hold) begin
            r_ifid          <= i_load_dat;
        end
    end

    assign o_ifid_dat = r_ifid;

endmodule

// File: rtl/if_stage.sv
// RV32 instruction fetch: PC register, next-PC select, fetch fault check, IF/ID register, fetch counter.
// imem_addr comes straight from the PC register; the ROM answer is captured one edge later.
module if_stage
    import rv32_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = rv32_pipe_pkg::RESET_PC_DEF,
    parameter int          IMEM_WORDS = 4096,
    parameter logic [31:0] NOP_INST   = rv32_pipe_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall_if,
    input  logic        flush_if,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_fetch_fault,
    output logic [31:0] fetch_count
);

    // 33 bits so a 4 GiB memory size does not overflow the limit compare
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

    logic [31:0] r_pc;
    logic [31:0] r_fetch_count;
    logic [31:0] w_pc_plus4;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_fault;
    logic        w_bubble;
    logic        w_load;
    ifid_t       w_load_dat;
    ifid_t       w_ifid;

    assign w_pc_plus4     = pc_inc(r_pc);
    assign w_misaligned   = (r_pc[1:0] != 2'b00);
    assign w_out_of_range = ({1'b0, r_pc} >= IMEM_BYTES);
    assign w_fault        = w_misaligned | w_out_of_range;

    assign w_bubble = redirect_valid | flush_if;
    assign w_load   = !w_bubble && !stall_if;

    // Redirect beats stall so a taken branch is never lost behind a load-use hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (!stall_if) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    always_comb begin
        w_load_dat          = '0;
        w_load_dat.pc       = r_pc;
        w_load_dat.pc_plus4 = w_pc_plus4;
        w_load_dat.valid    = 1'b1;
        w_load_dat.fault    = w_fault;
        w_load_dat.inst     = w_fault ? NOP_INST : imem_data;
    end

    if_id_reg #(
        .BUBBLE_INST (NOP_INST)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_bubble   (w_bubble),
        .i_hold     (stall_if),
        .i_load_dat (w_load_dat),
        .o_ifid_dat (w_ifid)
    );

    assign imem_addr      = r_pc;
    assign id_pc          = w_ifid.pc;
    assign id_pc_plus4    = w_ifid.pc_plus4;
    assign id_inst        = w_ifid.inst;
    assign id_valid       = w_ifid.valid;
    assign id_fetch_fault = w_ifid.fault;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a combinational ROM where word i holds 32'h1000_0000 + i.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall_if;
    logic        flush_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_fetch_fault;
    logic [31:0] fetch_count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign imem_data = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    if_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (4096),
        .NOP_INST   (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall_if       (stall_if),
        .flush_if       (flush_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_inst        (id_inst),
        .id_valid       (id_valid),
        .id_fetch_fault (id_fetch_fault),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ip4;
        logic [31:0] inst;
        logic        v;
        logic        f;
        logic [31:0] cnt;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic s, input logic fl, input logic rv,
                       input logic [31:0] rpc, input logic [31:0] pc, input logic [31:0] ipc,
                       input logic [31:0] ip4, input logic [31:0] inst, input logic v,
                       input logic f, input logic [31:0] cnt);
        vec_t e;
        e.rst = r; e.stall = s; e.flush = fl; e.rv = rv; e.rpc = rpc;
        e.pc = pc; e.ipc = ipc; e.ip4 = ip4; e.inst = inst; e.v = v; e.f = f; e.cnt = cnt;
        tv.push_back(e);
    endtask

    task automatic drive(input logic r, input logic s, input logic fl, input logic rv,
                         input logic [31:0] rpc);
        rst = r; stall_if = s; flush_if = fl; redirect_valid = rv; redirect_pc = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] pc, input logic [31:0] ipc,
                         input logic [31:0] ip4, input logic [31:0] inst, input logic v,
                         input logic f, input logic [31:0] cnt);
        n_vec++;
        if (imem_addr !== pc) begin
            n_miss++;
            $display("FAIL %s imem_addr got %h want %h", name, imem_addr, pc);
        end
        if (id_pc !== ipc) begin
            n_miss++;
            $display("FAIL %s id_pc got %h want %h", name, id_pc, ipc);
        end
        if (id_pc_plus4 !== ip4) begin
            n_miss++;
            $display("FAIL %s id_pc_plus4 got %h want %h", name, id_pc_plus4, ip4);
        end
        if (id_inst !== inst) begin
            n_miss++;
            $display("FAIL %s id_inst got %h want %h", name, id_inst, inst);
        end
        if (id_valid !== v) begin
            n_miss++;
            $display("FAIL %s id_valid got %b want %b", name, id_valid, v);
        end
        if (id_fetch_fault !== f) begin
            n_miss++;
            $display("FAIL %s id_fetch_fault got %b want %b", name, id_fetch_fault, f);
        end
        if (fetch_count !== cnt) begin
            n_miss++;
            $display("FAIL %s fetch_count got %0d want %0d", name, fetch_count, cnt);
        end
    endtask

    initial begin
        //   rst stl fls rv  rpc            pc             id_pc          id_pc+4        inst           v  f  cnt
        add(1, 0, 0, 0, 32'h0,          32'h0,          32'h0,          32'h4,          NOP,           0, 0, 0);
        add(0, 0, 0, 0, 32'h0,          32'h4,          32'h0,          32'h4,          32'h1000_0000, 1, 0, 1);
        add(0, 0, 0, 0, 32'h0,          32'h8,          32'h4,          32'h8,          32'h1000_0001, 1, 0, 2);
        add(0, 1, 0, 0, 32'h0,          32'h8,          32'h4,          32'h8,          32'h1000_0001, 1, 0, 2);
        add(0, 1, 0, 0, 32'h0,          32'h8,          32'h4,          32'h8,          32'h1000_0001, 1, 0, 2);
        add(0, 0, 0, 0, 32'h0,          32'hC,          32'h8,          32'hC,          32'h1000_0002, 1, 0, 3);
        add(0, 1, 0, 1, 32'h40,         32'h40,         32'h8,          32'hC,          NOP,           0, 0, 3);
        add(0, 0, 0, 0, 32'h0,          32'h44,         32'h40,         32'h44,         32'h1000_0010, 1, 0, 4);
        add(0, 0, 0, 1, 32'h42,         32'h42,         32'h40,         32'h44,         NOP,           0, 0, 4);
        add(0, 0, 0, 0, 32'h0,          32'h46,         32'h42,         32'h46,         NOP,           1, 1, 5);
        add(0, 0, 0, 1, 32'h4000,       32'h4000,       32'h42,         32'h46,         NOP,           0, 0, 5);
        add(0, 0, 0, 0, 32'h0,          32'h4004,       32'h4000,       32'h4004,       NOP,           1, 1, 6);
        add(0, 0, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC,  32'h4000,       32'h4004,       NOP,           0, 0, 6);
        add(0, 0, 0, 0, 32'h0,          32'h0,          32'hFFFF_FFFC,  32'h0,          NOP,           1, 1, 7);
        add(0, 0, 0, 0, 32'h0,          32'h4,          32'h0,          32'h4,          32'h1000_0000, 1, 0, 8);
        add(0, 1, 1, 0, 32'h0,          32'h4,          32'h0,          32'h4,          NOP,           0, 0, 8);
        add(0, 0, 0, 0, 32'h0,          32'h8,          32'h4,          32'h8,          32'h1000_0001, 1, 0, 9);
        add(1, 1, 0, 1, 32'h80,         32'h0,          32'h0,          32'h4,          NOP,           0, 0, 0);
        add(0, 0, 0, 0, 32'h0,          32'h4,          32'h0,          32'h4,          32'h1000_0000, 1, 0, 1);
        add(0, 0, 1, 0, 32'h0,          32'h8,          32'h0,          32'h4,          NOP,           0, 0, 1);
        add(0, 0, 0, 0, 32'h0,          32'hC,          32'h8,          32'hC,          32'h1000_0002, 1, 0, 2);

        drive(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].stall, tv[i].flush, tv[i].rv, tv[i].rpc);
            step();
            check($sformatf("vec%0d", i), tv[i].pc, tv[i].ipc, tv[i].ip4, tv[i].inst,
                  tv[i].v, tv[i].f, tv[i].cnt);
        end

        // Last in-range word, then the first out-of-range one reached sequentially.
        drive(0, 0, 0, 1, 32'h3FFC);
        step();
        check("lastword_redir", 32'h3FFC, 32'h8, 32'hC, NOP, 0, 0, 2);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("lastword_load", 32'h4000, 32'h3FFC, 32'h4000, 32'h1000_0FFF, 1, 0, 3);
        step();
        check("limit_fault", 32'h4004, 32'h4000, 32'h4004, NOP, 1, 1, 4);

        // Misaligned by one byte, and reset landing in the middle of a stall.
        drive(0, 0, 0, 1, 32'h41);
        step();
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("misalign1", 32'h45, 32'h41, 32'h45, NOP, 1, 1, 5);
        drive(0, 1, 0, 0, 32'h0);
        step();
        check("stall_pre_rst", 32'h45, 32'h41, 32'h45, NOP, 1, 1, 5);
        drive(1, 1, 0, 0, 32'h0);
        step();
        check("rst_in_stall", 32'h0, 32'h0, 32'h4, NOP, 0, 0, 0);
        drive(0, 1, 0, 0, 32'h0);
        step();
        check("stall_after_rst", 32'h0, 32'h0, 32'h4, NOP, 0, 0, 0);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("release_after_rst", 32'h4, 32'h0, 32'h4, 32'h1000_0000, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
